// File: rtl/sprite_anim_core.sv
// Parametrised sprite generator: palette lookup, X/Y mirroring and frame animation
// (manual, loop, ping-pong, one-shot), one pixel per clock with a two-clock latency.
module sprite_anim_core #(
  parameter int CD = 12,
  parameter int H_SIZE = 32,
  parameter int V_SIZE = 32,
  parameter int NFRAME = 4,
  parameter int PW = 3,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  parameter INIT_FILE = "sprite.txt",
  localparam int XB = $clog2(H_SIZE),
  localparam int YB = $clog2(V_SIZE),
  localparam int FB = $clog2(NFRAME),
  localparam int ADDR = FB + YB + XB,
  localparam int FW = (FB > 0) ? FB : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic [10:0]   x0,
  input  logic [10:0]   y0,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] frame_sel,
  input  logic [3:0]    rate,
  input  logic          mirror_x,
  input  logic          mirror_y,
  input  logic          start,
  input  logic          we,
  input  logic [ADDR-1:0] addr_w,
  input  logic [PW-1:0] pixel_in,
  input  logic          plt_we,
  input  logic [PW-1:0] plt_addr,
  input  logic [CD-1:0] plt_data,
  output logic [CD-1:0] sprite_rgb,
  output logic [FW-1:0] cur_frame,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [FW-1:0] LAST = FW'(NFRAME - 1);

  logic [PW-1:0] mem [2**ADDR];
  logic [CD-1:0] pal_q [2**PW];

  logic [11:0]     xr, yr;
  logic            in_region;
  logic [XB-1:0]   xe;
  logic [YB-1:0]   ye;
  logic [ADDR-1:0] rd_addr;
  logic [PW-1:0]   code_q;
  logic            in_q;
  logic [CD-1:0]   rgb_q;

  logic [FW-1:0] frame_q, frame_d, man_frame, pp_nxt;
  logic [3:0]    cnt_q, cnt_d;
  logic          dir_up_q, dir_up_d;
  logic [1:0]    st_q, st_d;
  logic          done_q, done_d;
  logic [1:0]    mode_q;
  logic [10:0]   x_d1_q;
  logic          frame_tick, step;

  // Negative offsets wrap to large unsigned values, so one compare covers both bounds.
  assign xr = {1'b0, x} - {1'b0, x0};
  assign yr = {1'b0, y} - {1'b0, y0};
  assign in_region = (xr < 12'(H_SIZE)) && (yr < 12'(V_SIZE));
  assign xe = mirror_x ? ~xr[XB-1:0] : xr[XB-1:0];
  assign ye = mirror_y ? ~yr[YB-1:0] : yr[YB-1:0];

  if (FB > 0) begin : g_frame_addr
    assign rd_addr = {frame_q[FB-1:0], ye, xe};
  end else begin : g_single_frame
    assign rd_addr = {ye, xe};
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
      in_q   <= 1'b0;
      rgb_q  <= KEY_COLOR;
      for (int i = 0; i < 2**PW; i++) pal_q[i] <= '0;
    end else begin
      code_q <= mem[rd_addr];
      in_q   <= in_region;
      rgb_q  <= (in_q && code_q != '0) ? pal_q[code_q] : KEY_COLOR;
      if (plt_we) pal_q[plt_addr] <= plt_data;
    end
  end

  assign frame_tick = (x_d1_q == 11'd0) && (x == 11'd1) && (y == 11'd0);
  assign step       = frame_tick && (cnt_q == rate);
  assign man_frame  = (frame_sel > LAST) ? LAST : frame_sel;

  always_comb begin
    if (dir_up_q) pp_nxt = (frame_q == LAST) ? frame_q - 1'b1 : frame_q + 1'b1;
    else          pp_nxt = (frame_q == '0) ? frame_q + 1'b1 : frame_q - 1'b1;
  end

  always_comb begin
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    st_d     = st_q;
    done_d   = 1'b0;
    if (frame_tick) cnt_d = step ? 4'd0 : cnt_q + 4'd1;
    if (mode_q != mode) begin
      frame_d  = '0;
      cnt_d    = 4'd0;
      dir_up_d = 1'b1;
      st_d     = ST_IDLE;
    end else begin
      case (mode)
        2'b00: frame_d = man_frame;
        2'b01: if (step) frame_d = (frame_q == LAST) ? '0 : frame_q + 1'b1;
        2'b10: begin
          if (step && NFRAME > 1) begin
            frame_d = pp_nxt;
            if (pp_nxt == LAST)    dir_up_d = 1'b0;
            else if (pp_nxt == '0) dir_up_d = 1'b1;
          end
        end
        default: begin
          case (st_q)
            ST_PLAY: begin
              if (step && FW'(frame_q + 1'b1) == LAST) begin
                frame_d = LAST;
                st_d    = ST_DONE;
                done_d  = 1'b1;
              end else if (step) begin
                frame_d = frame_q + 1'b1;
              end
            end
            default: begin
              frame_d = (st_q == ST_DONE) ? LAST : '0;
              // Start outranks a coincident step: restart from frame 0 with a fresh count.
              if (start) begin
                frame_d = '0;
                cnt_d   = 4'd0;
                if (NFRAME == 1) begin
                  st_d   = ST_DONE;
                  done_d = 1'b1;
                end else begin
                  st_d = ST_PLAY;
                end
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q  <= '0;
      cnt_q    <= 4'd0;
      dir_up_q <= 1'b1;
      st_q     <= ST_IDLE;
      done_q   <= 1'b0;
      mode_q   <= 2'b00;
      x_d1_q   <= 11'd0;
    end else begin
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      st_q     <= st_d;
      done_q   <= done_d;
      mode_q   <= mode;
      x_d1_q   <= x;
    end
  end

  assign sprite_rgb = rgb_q;
  assign cur_frame  = frame_q;
  assign busy       = (st_q == ST_PLAY);
  assign done       = done_q;

endmodule

// File: doc/sprite_anim_core.md
Name: sprite_anim_core

Overview:
Parametrised sprite generator for the video overlay chain, generalising the fixed 32x32, 4-frame player core. Sprite size, frame count and palette width are parameters. Adds a writable palette, X/Y mirroring, a programmable animation rate and four animation modes (manual, loop, ping-pong, one-shot). It sits in a sprite slot between the pixel-coordinate generator and the chroma-key blender, producing one pixel per clock.

Parameters:
CD, 12, colour depth of palette entries and output
H_SIZE, 32, sprite width in pixels (power of 2, >=2)
V_SIZE, 32, sprite height in pixels (power of 2, >=2)
NFRAME, 4, animation frames stored (power of 2, >=1)
PW, 3, palette code width; palette holds 2**PW entries
KEY_COLOR, 0, chroma-key colour output for transparent/out-of-region pixels
INIT_FILE, "sprite.txt", sprite RAM initialisation file
(derived) ADDR = log2(NFRAME)+log2(V_SIZE)+log2(H_SIZE); FW = max(1,log2(NFRAME))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
x, y  in  11  current pixel coordinate
x0, y0  in  11  sprite origin (top-left)
mode  in  2  00 manual, 01 loop, 10 ping-pong, 11 one-shot
frame_sel  in  FW  frame shown in manual mode
rate  in  4  frame ticks per animation step minus 1
mirror_x, mirror_y  in  1  horizontal/vertical flip
start  in  1  one-shot trigger pulse
we  in  1  sprite RAM write enable
addr_w  in  ADDR  sprite RAM write address
pixel_in  in  PW  sprite RAM write data (palette code)
plt_we  in  1  palette write enable
plt_addr  in  PW  palette entry index
plt_data  in  CD  palette entry colour
sprite_rgb  out  CD  pixel colour
cur_frame  out  FW  frame currently displayed
busy  out  1  one-shot playing
done  out  1  one-cycle pulse when one-shot reaches last frame

Behaviour:
- Reset: sprite_rgb=KEY_COLOR, cur_frame=0, busy=0, done=0, rate counter=0, direction=up, one-shot state IDLE, all palette entries=0, pipeline registers cleared. Sprite RAM contents are not reset.
- Relative coords: xr=x-x0, yr=y-y0, 12-bit signed. in_region = 0<=xr<H_SIZE and 0<=yr<V_SIZE.
- Mirroring: xe = mirror_x ? H_SIZE-1-xr : xr; ye likewise with mirror_y and V_SIZE.
- Read address = {cur_frame, ye[low bits], xe[low bits]}.
- Pipeline, latency exactly 2 clocks from x,y to sprite_rgb:
  - Stage 1: synchronous RAM read, with in_region registered alongside.
  - Stage 2: registered output = (in_region_d && code!=0) ? palette[code] : KEY_COLOR.
  - Code 0 is always transparent, regardless of palette[0].
- Write collisions:
  - RAM write and read to the same address in the same cycle return old data.
  - A palette write takes effect on the next cycle.
- frame_tick = (x_d1==0 && x==1 && y==0), where x_d1 is x delayed one clock.
- Rate counter: increments on frame_tick. On frame_tick with count==rate, the counter returns to 0 and issues step. rate=0 gives one step per frame.
- Mode 00: cur_frame = min(frame_sel, NFRAME-1), registered; counter runs but is ignored.
- Mode 01: each step, cur_frame+1, wrapping NFRAME-1 -> 0.
- Mode 10: step moves up or down.
  - At NFRAME-1 the direction flips to down; at 0 it flips to up. Endpoints are shown for one step only: 0,1,2,3,2,1,0,1...
  - NFRAME=1 holds 0.
- Mode 11 FSM:
  - IDLE (frame 0, busy=0): start -> PLAY (frame 0, counter=0, busy=1).
  - PLAY: each step increments the frame. The step arriving at frame NFRAME-1 -> DONE, done=1 for one cycle.
  - DONE: holds NFRAME-1, busy=0.
  - start in PLAY is ignored; start in DONE -> PLAY from frame 0.
  - NFRAME=1: start -> DONE immediately, with a done pulse.
- mode change (registered mode != mode): cur_frame=0, counter=0, direction=up, FSM=IDLE, all in the same cycle.
- start coinciding with step: start wins in IDLE/DONE.
- reset mid-animation returns everything to the reset values above on the next edge.

Test Plan:
- Reset, write palette[2]=12'hec9, RAM code 2 at (0,0) frame 0; x0=y0=100, scan x=100,y=100 -> sprite_rgb=12'hec9 two clocks later; x=99 -> KEY_COLOR; code 0 pixel -> KEY_COLOR even if palette[0]=12'hfff.
- mirror_x=1, distinct codes at columns 0 and 31 -> pixel at x=x0 shows column-31 colour; mirror_y checked likewise at row V_SIZE-1.
- mode=01, rate=2, NFRAME=4, emulate 24 frame ticks -> cur_frame steps every 3 ticks: 0,1,2,3,0,1,2,3.
- mode=10, rate=0 -> cur_frame sequence 0,1,2,3,2,1,0,1 over 8 ticks.
- mode=11, rate=0: start -> busy=1; after 3 ticks cur_frame=3, done one-cycle, busy=0; start during PLAY ignored; start in DONE restarts at 0.
- mode=00, frame_sel=3 then switch to 01 mid-count -> cur_frame=0 and counter cleared the cycle after the change; reset asserted during PLAY -> busy=0, cur_frame=0, palette entries 0.
